// File: rtl/fxp_pkg.sv
// fxp_pkg: fixed-point formats and limits shared by the Q24.8 -> Q8.8 multiplier
//   Q_IN_W/Q_IN_FRAC    operand width and fractional bits (Q24.8)
//   Q_OUT_W/Q_OUT_FRAC  result width and fractional bits (Q8.8)
//   OUT_MAX/OUT_MIN     representable limits of the Q8.8 result
package fxp_pkg;
    localparam int Q_IN_W     = 32;
    localparam int Q_IN_FRAC  = 8;
    localparam int Q_OUT_W    = 16;
    localparam int Q_OUT_FRAC = 8;
    localparam int SHIFT      = Q_IN_FRAC + Q_IN_FRAC - Q_OUT_FRAC;
    localparam int S_W        = 2 * Q_IN_W - SHIFT;
    typedef logic signed [Q_IN_W-1:0]  q24p8_t;
    typedef logic signed [Q_OUT_W-1:0] q8p8_t;
    localparam q8p8_t OUT_MAX = 16'sh7FFF;
    localparam q8p8_t OUT_MIN = 16'sh8000;
endpackage

// File: rtl/sat_narrow.sv
// sat_narrow: caps a signed wide value into the Q8.8 result range
//   x    in   W        signed wide value
//   y    out  Q_OUT_W  capped value
//   ovf  out  1        x was above OUT_MAX
//   unf  out  1        x was below OUT_MIN
module sat_narrow
    import fxp_pkg::*;
#(
    parameter int W = S_W
) (
    input  logic signed [W-1:0] x,
    output q8p8_t               y,
    output logic                ovf,
    output logic                unf
);
    // Limits sign-extended to the full input width so no upper bits are dropped.
    localparam logic signed [W-1:0] MAX_W = {{(W-Q_OUT_W){1'b0}}, OUT_MAX};
    localparam logic signed [W-1:0] MIN_W = {{(W-Q_OUT_W){1'b1}}, OUT_MIN};
    always_comb begin
        ovf = x > MAX_W;
        unf = x < MIN_W;
        y   = ovf ? OUT_MAX : unf ? OUT_MIN : x[Q_OUT_W-1:0];
    end
endmodule

// File: rtl/capped_mult_q8p8.sv
// capped_mult_q8p8: Q24.8 x Q24.8 multiply, truncated and capped to Q8.8, one registered stage
//   clk          in   1   rising-edge clock
//   rst_n        in   1   synchronous reset, active-low
//   a_in, b_in   in   32  signed Q24.8 operands
//   p_out        out  16  signed capped product, Q8.8
//   overflow     out  1   product capped at OUT_MAX
//   underflow_q  out  1   product capped at OUT_MIN
module capped_mult_q8p8
    import fxp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [Q_IN_W-1:0]   a_in,
    input  logic [Q_IN_W-1:0]   b_in,
    output logic [Q_OUT_W-1:0]  p_out,
    output logic                overflow,
    output logic                underflow_q
);
    logic signed [2*Q_IN_W-1:0] a_ext;
    logic signed [2*Q_IN_W-1:0] b_ext;
    logic signed [2*Q_IN_W-1:0] full;
    logic signed [S_W-1:0]      s;
    q8p8_t                      y;
    logic                       ovf;
    logic                       unf;
    // Operands widened before multiplying so the 64-bit product is exact.
    assign a_ext = {{Q_IN_W{a_in[Q_IN_W-1]}}, a_in};
    assign b_ext = {{Q_IN_W{b_in[Q_IN_W-1]}}, b_in};
    assign full  = a_ext * b_ext;
    // Dropping the low SHIFT bits is an arithmetic shift: truncation toward -inf.
    assign s     = full[2*Q_IN_W-1:SHIFT];
    sat_narrow #(.W(S_W)) u_sat (
        .x   (s),
        .y   (y),
        .ovf (ovf),
        .unf (unf)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_out       <= '0;
            overflow    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            p_out       <= y;
            overflow    <= ovf;
            underflow_q <= unf;
        end
    end
endmodule

// File: tb/tb_capped_mult_q8p8.sv
// tb_capped_mult_q8p8: directed scoreboard bench for capped_mult_q8p8
module tb_capped_mult_q8p8;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [15:0] p_out;
    logic        overflow;
    logic        underflow_q;
    int          errors = 0;
    int          checks = 0;
    typedef struct {
        logic [17:0] v;
        string       tag;
    } exp_t;
    exp_t sb[$];
    always #5 clk = ~clk;
    capped_mult_q8p8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_in        (a_in),
        .b_in        (b_in),
        .p_out       (p_out),
        .overflow    (overflow),
        .underflow_q (underflow_q)
    );
    // Reference: exact 64-bit product, floor shift by 8, cap to Q8.8; packed {p, ovf, unf}.
    function automatic logic [17:0] model(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = (longint'($signed(a)) * longint'($signed(b))) >>> 8;
        if (s > 32767)  return {16'h7FFF, 2'b10};
        if (s < -32768) return {16'h8000, 2'b01};
        return {s[15:0], 2'b00};
    endfunction
    task automatic check_one();
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            assert ({p_out, overflow, underflow_q} === x.v) else begin
                errors++;
                $error("FAIL %s: got p=%h ovf=%b unf=%b, expected p=%h ovf=%b unf=%b",
                       x.tag, p_out, overflow, underflow_q, x.v[17:2], x.v[1], x.v[0]);
            end
        end
    endtask
    // One cycle: check the result of the previous cycle's inputs, then drive new ones.
    task automatic cycle(input logic r, input logic [31:0] a, input logic [31:0] b,
                         input logic [17:0] e, input string tag);
        @(negedge clk);
        check_one();
        rst_n = r;
        a_in  = a;
        b_in  = b;
        sb.push_back('{e, tag});
    endtask
    initial begin
        logic [31:0] a;
        logic [31:0] b;
        cycle(1'b0, $urandom, $urandom, 18'h0, "reset0");
        cycle(1'b0, $urandom, $urandom, 18'h0, "reset1");
        cycle(1'b1, 32'h00000100, 32'h00000100, {16'h0100, 2'b00}, "one_x_one");
        cycle(1'b1, 32'hFFFFF900, 32'h00000900, {16'hC100, 2'b00}, "neg7_x_9");
        cycle(1'b1, 32'h00000080, 32'h00000080, {16'h0040, 2'b00}, "half_sq");
        cycle(1'b1, 32'h00001000, 32'h00000800, {16'h7FFF, 2'b10}, "ovf_16x8");
        cycle(1'b1, 32'hFFFFF100, 32'h00001100, {16'h8000, 2'b01}, "unf_m15x17");
        cycle(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, {16'h7FFF, 2'b10}, "ovf_max_sq");
        cycle(1'b1, 32'hFFFFF000, 32'h00000800, {16'h8000, 2'b00}, "exact_min");
        cycle(1'b1, 32'h00000001, 32'h00000001, {16'h0000, 2'b00}, "trunc_pos");
        cycle(1'b1, 32'hFFFFFFFF, 32'h00000001, {16'hFFFF, 2'b00}, "trunc_neg");
        cycle(1'b1, 32'h00000000, 32'h80000000, {16'h0000, 2'b00}, "zero_op");
        cycle(1'b1, 32'h00000000, 32'h00000000, 18'h0, "gap");
        // Back-to-back ramp with a one-cycle reset at step 5.
        for (int i = 0; i < 10; i++) begin
            a = 32'h00000100 - 32'(i) * 32'h00000800;
            b = 32'h00000100 + 32'(i) * 32'h00000800;
            if (i == 5) cycle(1'b0, a, b, 18'h0, $sformatf("ramp%0d_rst", i));
            else        cycle(1'b1, a, b, model(a, b), $sformatf("ramp%0d", i));
        end
        cycle(1'b1, 32'h00000300, 32'hFFFFFE00, model(32'h00000300, 32'hFFFFFE00), "after_ramp");
        @(negedge clk);
        check_one();
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
